// File: rtl/jam_cost_server_if.sv
// jam_cost_server_if: cost-lookup and result bus between the JAM engine and the cost server
interface jam_cost_server_if;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;
  logic       Valid;
  modport master (output W, J, MatchCount, MinCost, Valid, input Cost);
  modport slave  (input W, J, MatchCount, MinCost, Valid, output Cost);
endinterface

// File: rtl/jam_cost_server.sv
// jam_cost_server: 8x8 cost ROM for the JAM engine plus a result self-check with timeout
module jam_cost_server #(
  parameter int TIMEOUT = 1000000,
  parameter int CW = 20
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Load_en,
  input  logic [6:0]        Load_data,
  input  logic              Start,
  input  logic [9:0]        Exp_MinCost,
  input  logic [3:0]        Exp_MatchCount,
  jam_cost_server_if.slave  bus,
  output logic              Load_done,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic              Timeout,
  output logic [CW-1:0]     Cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, SERVE, DONE} state_t;
  state_t state, state_n;
  logic [6:0] mem [64];
  logic [5:0] addr, addr_n;
  logic [9:0] exp_min;
  logic [3:0] exp_cnt;
  logic we, cap, ld_n, busy_n, done_n, pass_n, to_n;
  logic [CW-1:0] cyc_n;
  assign bus.Cost = mem[{bus.W, bus.J}];
  // Matrix storage is never reset so a reset does not wipe a loaded table
  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= Load_data;
    if (cap) begin
      exp_min <= Exp_MinCost;
      exp_cnt <= Exp_MatchCount;
    end
  end
  // State, load address and registered status outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      addr      <= '0;
      Load_done <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      Timeout   <= 1'b0;
      Cycles    <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      Load_done <= ld_n;
      Busy      <= busy_n;
      Done      <= done_n;
      Pass      <= pass_n;
      Timeout   <= to_n;
      Cycles    <= cyc_n;
    end
  end
  // Next-state and next-status logic; Load_en takes priority over Start
  always_comb begin
    state_n = state;
    addr_n  = addr;
    we      = 1'b0;
    cap     = 1'b0;
    ld_n    = Load_done;
    busy_n  = Busy;
    done_n  = Done;
    pass_n  = Pass;
    to_n    = Timeout;
    cyc_n   = Cycles;
    case (state)
      IDLE: if (Load_en) begin
        we      = 1'b1;
        addr_n  = 6'd1;
        state_n = LOAD;
      end
      LOAD: if (Load_en) begin
        we     = 1'b1;
        addr_n = addr + 6'd1;
        if (addr == 6'd63) begin
          ld_n    = 1'b1;
          state_n = READY;
        end
      end
      READY, DONE: if (Load_en) begin
        we      = 1'b1;
        addr_n  = 6'd1;
        ld_n    = 1'b0;
        done_n  = 1'b0;
        pass_n  = 1'b0;
        to_n    = 1'b0;
        state_n = LOAD;
      end else if (Start) begin
        cap     = 1'b1;
        cyc_n   = '0;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        pass_n  = 1'b0;
        to_n    = 1'b0;
        state_n = SERVE;
      end
      SERVE: if (bus.Valid) begin
        pass_n  = (bus.MinCost == exp_min) && (bus.MatchCount == exp_cnt);
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = DONE;
      end else if (Cycles == CW'(TIMEOUT - 1)) begin
        cyc_n   = CW'(TIMEOUT);
        to_n    = 1'b1;
        pass_n  = 1'b0;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = DONE;
      end else begin
        cyc_n = Cycles + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: directed checks of loading, lookup, pass/fail and timeout
module tb_jam_cost_server;
  logic CLK = 1'b0, RST_N = 1'b0, Load_en = 1'b0, Start = 1'b0;
  logic [6:0] Load_data = '0;
  logic [9:0] Exp_MinCost = '0;
  logic [3:0] Exp_MatchCount = '0;
  logic a_ld, a_busy, a_done, a_pass, a_to;
  logic [19:0] a_cyc;
  logic b_ld, b_busy, b_done, b_pass, b_to;
  logic [5:0] b_cyc;
  int checks = 0, errors = 0;
  jam_cost_server_if bus0();
  jam_cost_server_if bus1();
  jam_cost_server u_dut (
    .CLK(CLK), .RST_N(RST_N), .Load_en(Load_en), .Load_data(Load_data), .Start(Start),
    .Exp_MinCost(Exp_MinCost), .Exp_MatchCount(Exp_MatchCount), .bus(bus0),
    .Load_done(a_ld), .Busy(a_busy), .Done(a_done), .Pass(a_pass), .Timeout(a_to), .Cycles(a_cyc)
  );
  jam_cost_server #(.TIMEOUT(50), .CW(6)) u_t50 (
    .CLK(CLK), .RST_N(RST_N), .Load_en(Load_en), .Load_data(Load_data), .Start(Start),
    .Exp_MinCost(Exp_MinCost), .Exp_MatchCount(Exp_MatchCount), .bus(bus1),
    .Load_done(b_ld), .Busy(b_busy), .Done(b_done), .Pass(b_pass), .Timeout(b_to), .Cycles(b_cyc)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic load_word(input logic [6:0] d);
    Load_en = 1'b1;
    Load_data = d;
    tick();
    Load_en = 1'b0;
  endtask
  initial begin
    bus0.W = '0; bus0.J = '0; bus0.Valid = 1'b0; bus0.MinCost = '0; bus0.MatchCount = '0;
    bus1.W = '0; bus1.J = '0; bus1.Valid = 1'b0; bus1.MinCost = '0; bus1.MatchCount = '0;
    tick(); tick();
    RST_N = 1'b1;
    check("rst_load_done", a_ld, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_pass", a_pass, 0);
    check("rst_timeout", a_to, 0);
    check("rst_cycles", a_cyc, 0);
    Start = 1'b1; tick(); Start = 1'b0;
    check("idle_start_ignored", a_busy, 0);
    for (int a = 0; a < 64; a++) begin
      load_word(7'(a));
      if (a == 10) begin
        repeat (3) tick();
        check("gap_load_done", a_ld, 0);
      end
      if (a == 62) check("pre_last_load_done", a_ld, 0);
    end
    check("load_done", a_ld, 1);
    bus0.W = 3'd3; bus0.J = 3'd5; #1;
    check("cost_w3j5", bus0.Cost, 29);
    bus0.W = 3'd7; bus0.J = 3'd7; #1;
    check("cost_w7j7", bus0.Cost, 63);
    Exp_MinCost = 10'd252; Exp_MatchCount = 4'd0;
    Start = 1'b1; tick(); Start = 1'b0;
    check("serve_busy", a_busy, 1);
    repeat (100) tick();
    check("t50_done", b_done, 1);
    check("t50_timeout", b_to, 1);
    check("t50_pass", b_pass, 0);
    check("t50_cycles", b_cyc, 50);
    check("t50_busy", b_busy, 0);
    check("serve_cycles_100", a_cyc, 100);
    bus0.Valid = 1'b1; bus0.MinCost = 10'd252; bus0.MatchCount = 4'd0;
    tick();
    bus0.Valid = 1'b0;
    check("p1_done", a_done, 1);
    check("p1_pass", a_pass, 1);
    check("p1_cycles", a_cyc, 100);
    check("p1_busy", a_busy, 0);
    check("p1_timeout", a_to, 0);
    Start = 1'b1; tick(); Start = 1'b0;
    check("restart_done_clr", a_done, 0);
    check("restart_busy", a_busy, 1);
    repeat (49) tick();
    check("t50_pre_cycles", b_cyc, 49);
    check("t50_pre_timeout", b_to, 0);
    bus0.Valid = 1'b1; bus0.MinCost = 10'd251; bus0.MatchCount = 4'd0;
    bus1.Valid = 1'b1; bus1.MinCost = 10'd252; bus1.MatchCount = 4'd0;
    tick();
    bus0.Valid = 1'b0; bus1.Valid = 1'b0;
    check("p2_done", a_done, 1);
    check("p2_pass", a_pass, 0);
    check("p2_timeout", a_to, 0);
    check("p2_cycles", a_cyc, 49);
    check("t50_valid_done", b_done, 1);
    check("t50_valid_timeout", b_to, 0);
    check("t50_valid_pass", b_pass, 1);
    check("t50_valid_cycles", b_cyc, 49);
    for (int a = 0; a < 20; a++) load_word(7'(100 + a));
    check("partial_load_done", a_ld, 0);
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    check("rst2_load_done", a_ld, 0);
    check("rst2_done", a_done, 0);
    check("rst2_cycles", a_cyc, 0);
    bus0.W = 3'd1; bus0.J = 3'd2; #1;
    check("mem_kept_after_rst", bus0.Cost, 110);
    for (int a = 0; a < 64; a++) load_word(7'(63 - a));
    check("reload_done", a_ld, 1);
    bus0.W = 3'd0; bus0.J = 3'd0; #1;
    check("reload_w0j0", bus0.Cost, 63);
    bus0.W = 3'd7; bus0.J = 3'd7; #1;
    check("reload_w7j7", bus0.Cost, 0);
    bus0.W = 3'd0; bus0.J = 3'd0;
    Load_en = 1'b1; Load_data = 7'd99; Start = 1'b1; #1;
    check("old_value_before_edge", bus0.Cost, 63);
    tick();
    Load_en = 1'b0; Start = 1'b0;
    check("ld_wins_load_done", a_ld, 0);
    check("ld_wins_busy", a_busy, 0);
    check("ld_wins_mem0", bus0.Cost, 99);
    Start = 1'b1; tick(); Start = 1'b0;
    check("load_start_ignored", a_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
